boot_rom_prefetch: RTL and testbench
====================================

Name: boot_rom_prefetch

Overview:
- Single-line read prefetch buffer between the SoC interconnect (slave side) and the boot ROM port (master side).
- Serves repeated sequential boot-code fetches from a local line of LINE_WORDS words. Hits take 1 cycle; on a miss, the whole aligned line is burst-read from the ROM.
- Writes are rejected with an error response and never reach the ROM.
- Downstream ROM protocol: grant is combinational with request; read data is valid exactly 1 cycle after grant.

Parameters:
- ADDR_WIDTH, 32, byte address width on both sides.
- DATA_WIDTH, 32, word width.
- LINE_WORDS, 4, words per line. Must be a power of 2 and ≥2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- flush_i  in  1  invalidate the line buffer (1-cycle pulse).
- s_req_i  in  1  slave request.
- s_add_i  in  ADDR_WIDTH  slave byte address.
- s_wen_i  in  1  1 = read, 0 = write.
- s_wdata_i  in  DATA_WIDTH  write data; ignored.
- s_be_i  in  DATA_WIDTH/8  byte enables; ignored.
- s_gnt_o  out  1  slave grant.
- s_r_valid_o  out  1  response valid.
- s_r_rdata_o  out  DATA_WIDTH  response data.
- s_r_opc_o  out  1  response error flag.
- m_req_o  out  1  ROM request.
- m_add_o  out  ADDR_WIDTH  ROM word-aligned byte address.
- m_wen_o  out  1  always 1 (read).
- m_gnt_i  in  1  ROM grant.
- m_r_valid_i  in  1  ROM response valid.
- m_r_rdata_i  in  DATA_WIDTH  ROM data.

Behaviour:
- Reset (rst_ni low at a clock edge) sets:
  - state = IDLE; line_valid = 0; issue_cnt = recv_cnt = 0; discard = 0.
  - s_r_valid_o = 0, s_r_rdata_o = 0, s_r_opc_o = 0.
  - m_req_o = 0, m_add_o = 0.
  - s_gnt_o is combinational and is 0 whenever s_req_i = 0.
- Address split:
  - OFS = log2(LINE_WORDS*4).
  - tag = s_add_i[ADDR_WIDTH-1:OFS]; word index = s_add_i[OFS-1:2].
  - Bits [1:0] are ignored.
- hit = line_valid & (tag == line_tag).
- State IDLE:
  - Write (s_req_i & !s_wen_i):
    - s_gnt_o = 1 in the same cycle.
    - Next cycle: s_r_valid_o = 1, s_r_opc_o = 1, s_r_rdata_o = 0.
  - Read hit:
    - s_gnt_o = 1 in the same cycle.
    - Next cycle: s_r_valid_o = 1, s_r_opc_o = 0, s_r_rdata_o = line[word index].
  - Read miss:
    - s_gnt_o = 0.
    - Latch line_base = {tag, OFS'b0}; clear line_valid and discard; go to FILL.
  - No request: s_r_valid_o = 0 next cycle.
- State FILL:
  - s_gnt_o = 0.
  - m_req_o = 1 while issue_cnt < LINE_WORDS, with m_add_o = line_base + 4*issue_cnt.
  - On each m_gnt_i, issue_cnt increments.
  - Each m_r_valid_i writes m_r_rdata_i into line[recv_cnt], then recv_cnt increments.
  - When recv_cnt reaches LINE_WORDS (last response cycle):
    - line_tag = latched tag; line_valid = !discard.
    - Go to IDLE.
  - A ROM that withholds grant stalls issue without losing words.
- Miss timing with a 0-wait ROM:
  - Miss seen in cycle 0; ROM requests in cycles 1..LINE_WORDS; responses in cycles 2..LINE_WORDS+1.
  - IDLE in cycle LINE_WORDS+2, where the held request hits.
  - s_r_valid_o in cycle LINE_WORDS+3, i.e. 7 for LINE_WORDS = 4.
- flush_i:
  - In IDLE: line_valid = 0 next cycle. A simultaneous request in that cycle is evaluated against the pre-flush line.
  - In FILL: sets discard. The fill completes, but the line stays invalid, so the held request misses again and refills.
- m_wen_o is tied to 1. The block never issues a ROM write.
- Reset in mid-FILL: everything returns to reset values; outstanding ROM responses after reset are ignored.
- s_r_valid_o is never asserted without a prior grant. At most one slave transaction is outstanding.

Test Plan:
- Cold read at 0x1A000008 (ROM returns word = address) -> m_add_o issues 0x1A000000, 04, 08, 0C on consecutive cycles; s_r_valid_o 7 cycles after s_req_i rises; s_r_rdata_o = 0x1A000008, s_r_opc_o = 0.
- Back-to-back reads 0x1A000000..0x1A00000C after the fill -> each granted the same cycle; r_valid the next cycle; no m_req_o activity.
- Write to 0x1A000004 -> s_gnt_o = 1 immediately; next cycle s_r_opc_o = 1, s_r_rdata_o = 0; m_req_o stays 0; line_valid unchanged.
- Read 0x1A000010 after the line 0x1A000000 is resident -> miss, refill of 0x1A000010..1C; data = 0x1A000010; a subsequent read of 0x1A000000 misses again.
- flush_i pulsed in the second FILL cycle -> the fill completes; the held request triggers a second 4-word fill before being granted.
- ROM withholds m_gnt_i for 3 cycles on the second word; separately, rst_ni is pulsed low in mid-FILL -> in the first case all 4 words are correct and in order; in the second, all outputs return to 0 and the next read performs a full fresh fill.

Source files
------------

// File: rtl/boot_rom_prefetch.sv
// Single-line read prefetch buffer between the interconnect and the boot ROM.
// Reads that hit the line are answered in one cycle; a miss burst-fills the aligned line.
module boot_rom_prefetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    s_req_i,
    input  logic [ADDR_WIDTH-1:0]   s_add_i,
    input  logic                    s_wen_i,
    input  logic [DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_be_i,
    output logic                    s_gnt_o,
    output logic                    s_r_valid_o,
    output logic [DATA_WIDTH-1:0]   s_r_rdata_o,
    output logic                    s_r_opc_o,
    output logic                    m_req_o,
    output logic [ADDR_WIDTH-1:0]   m_add_o,
    output logic                    m_wen_o,
    input  logic                    m_gnt_i,
    input  logic                    m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]   m_r_rdata_i
);
    localparam int OFS = $clog2(LINE_WORDS * 4);
    localparam int IW  = $clog2(LINE_WORDS);
    localparam int CW  = IW + 1;
    localparam int TW  = ADDR_WIDTH - OFS;

    typedef enum logic {IDLE, FILL} state_e;

    state_e                  state_q;
    logic                    line_valid_q;
    logic                    discard_q;
    logic [TW-1:0]           line_tag_q;
    logic [TW-1:0]           fill_tag_q;
    logic [CW-1:0]           issue_cnt_q;
    logic [CW-1:0]           recv_cnt_q;
    logic [DATA_WIDTH-1:0]   line_q [LINE_WORDS];
    logic                    s_r_valid_q;
    logic [DATA_WIDTH-1:0]   s_r_rdata_q;
    logic                    s_r_opc_q;
    logic                    m_req_q;
    logic [ADDR_WIDTH-1:0]   m_add_q;

    logic [TW-1:0]           tag;
    logic [IW-1:0]           word_idx;
    logic                    hit;
    logic                    rom_gnt;
    logic                    last_rsp;
    logic                    unused_inputs;

    assign tag      = s_add_i[ADDR_WIDTH-1:OFS];
    assign word_idx = s_add_i[OFS-1:2];
    assign hit      = line_valid_q && (tag == line_tag_q);
    assign rom_gnt  = m_req_q && m_gnt_i;
    assign last_rsp = m_r_valid_i && (recv_cnt_q == CW'(LINE_WORDS - 1));

    // Writes are always accepted (and rejected by response); reads only when resident.
    assign s_gnt_o = s_req_i && (state_q == IDLE) && (!s_wen_i || hit);

    assign s_r_valid_o = s_r_valid_q;
    assign s_r_rdata_o = s_r_rdata_q;
    assign s_r_opc_o   = s_r_opc_q;
    assign m_req_o     = m_req_q;
    assign m_add_o     = m_add_q;
    assign m_wen_o     = 1'b1;

    assign unused_inputs = ^{s_wdata_i, s_be_i, s_add_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            line_valid_q <= 1'b0;
            discard_q    <= 1'b0;
            line_tag_q   <= '0;
            fill_tag_q   <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            s_r_valid_q  <= 1'b0;
            s_r_rdata_q  <= '0;
            s_r_opc_q    <= 1'b0;
            m_req_q      <= 1'b0;
            m_add_q      <= '0;
        end else begin
            s_r_valid_q <= s_gnt_o;
            if (s_gnt_o) begin
                s_r_opc_q   <= !s_wen_i;
                s_r_rdata_q <= s_wen_i ? line_q[word_idx] : '0;
            end
            case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        line_valid_q <= 1'b0;
                    end
                    if (s_req_i && s_wen_i && !hit) begin
                        fill_tag_q   <= tag;
                        line_valid_q <= 1'b0;
                        discard_q    <= 1'b0;
                        issue_cnt_q  <= '0;
                        recv_cnt_q   <= '0;
                        m_req_q      <= 1'b1;
                        m_add_q      <= {tag, {OFS{1'b0}}};
                        state_q      <= FILL;
                    end
                end
                FILL: begin
                    if (flush_i) begin
                        discard_q <= 1'b1;
                    end
                    if (rom_gnt) begin
                        issue_cnt_q <= issue_cnt_q + CW'(1);
                        m_add_q     <= m_add_q + ADDR_WIDTH'(4);
                        m_req_q     <= (issue_cnt_q != CW'(LINE_WORDS - 1));
                    end
                    if (m_r_valid_i) begin
                        recv_cnt_q <= recv_cnt_q + CW'(1);
                    end
                    // A flush landing on the final response cycle must still invalidate.
                    if (last_rsp) begin
                        line_tag_q   <= fill_tag_q;
                        line_valid_q <= !(discard_q || flush_i);
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == FILL && m_r_valid_i) begin
            line_q[recv_cnt_q[IW-1:0]] <= m_r_rdata_i;
        end
    end
endmodule

// File: tb/tb_boot_rom_prefetch.sv
// Bench for boot_rom_prefetch: ROM model returning word = address, line-residency model,
// and queue-based scoreboards for slave responses and ROM request addresses.
module tb_boot_rom_prefetch;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int LINE_BYTES = LW * 4;
    localparam int MISS_LAT = LW + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          s_req_i = 1'b0;
    logic [AW-1:0] s_add_i = '0;
    logic          s_wen_i = 1'b1;
    logic [DW-1:0] s_wdata_i = '0;
    logic [DW/8-1:0] s_be_i = '0;
    logic          s_gnt_o;
    logic          s_r_valid_o;
    logic [DW-1:0] s_r_rdata_o;
    logic          s_r_opc_o;
    logic          m_req_o;
    logic [AW-1:0] m_add_o;
    logic          m_wen_o;
    logic          m_gnt_i;
    logic          m_r_valid_i;
    logic [DW-1:0] m_r_rdata_i;

    boot_rom_prefetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i),
        .s_wdata_i(s_wdata_i), .s_be_i(s_be_i), .s_gnt_o(s_gnt_o),
        .s_r_valid_o(s_r_valid_o), .s_r_rdata_o(s_r_rdata_o), .s_r_opc_o(s_r_opc_o),
        .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o),
        .m_gnt_i(m_gnt_i), .m_r_valid_i(m_r_valid_i), .m_r_rdata_i(m_r_rdata_i)
    );

    // ROM model: data = word address, answered exactly one cycle after grant.
    logic          gnt_block = 1'b0;
    logic          rom_valid = 1'b0;
    logic [DW-1:0] rom_data = '0;
    assign m_gnt_i     = m_req_o && !gnt_block;
    assign m_r_valid_i = rom_valid;
    assign m_r_rdata_i = rom_data;
    always @(posedge clk) begin
        rom_valid <= m_req_o && m_gnt_i;
        rom_data  <= m_add_o;
    end

    bit rand_stall = 1'b0;
    bit stall_arm = 1'b0;
    initial begin
        int hold;
        int grants_seen;
        logic g;
        hold = 0;
        grants_seen = 0;
        forever begin
            @(negedge clk);
            g = m_req_o && m_gnt_i;
            @(posedge clk);
            #1;
            if (!stall_arm) grants_seen = 0;
            else if (g) begin
                grants_seen++;
                if (grants_seen == 1) hold = 3;
            end
            if (hold > 0) begin
                gnt_block = 1'b1;
                hold--;
            end else begin
                gnt_block = rand_stall && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Scoreboard state
    int checks = 0;
    int failures = 0;
    logic [DW:0]   exp_q[$];
    logic [AW-1:0] rom_exp_q[$];
    bit rom_chk_en = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endtask

    // Monitor: response must follow a grant by one cycle; data/opc and ROM addresses popped in order.
    logic        prev_gnt = 1'b0;
    logic [DW:0] mon_e;
    always @(negedge clk) begin
        if (rst_ni) begin
            if (s_r_valid_o || prev_gnt) check("r_valid_after_gnt", s_r_valid_o, prev_gnt);
            if (s_r_valid_o) begin
                if (exp_q.size() == 0) fail_now("resp_unexpected", s_r_rdata_o);
                else begin
                    mon_e = exp_q.pop_front();
                    check("resp_opc", s_r_opc_o, mon_e[DW]);
                    check("resp_data", s_r_rdata_o, mon_e[DW-1:0]);
                end
            end
            if (m_req_o && m_gnt_i && rom_chk_en) begin
                check("rom_wen", m_wen_o, 1'b1);
                if (rom_exp_q.size() == 0) fail_now("rom_unexpected", m_add_o);
                else check("rom_addr", m_add_o, rom_exp_q.pop_front());
            end
        end
        prev_gnt = s_req_i && s_gnt_o && rst_ni;
    end

    // Reference model of line residency, in line numbers.
    bit          m_valid = 1'b0;
    int unsigned m_line = 0;

    task automatic expect_fill(input logic [AW-1:0] addr);
        logic [AW-1:0] base;
        base = addr - (addr % LINE_BYTES);
        for (int i = 0; i < LW; i++) rom_exp_q.push_back(base + AW'(4 * i));
    endtask

    task automatic access(input bit is_wr, input logic [AW-1:0] addr, input bit flush_with,
                          output int lat, output bit fast);
        bit got;
        bit will_hit;
        will_hit = m_valid && (addr / LINE_BYTES == m_line);
        fast = is_wr || will_hit;
        if (!fast) expect_fill(addr);
        s_req_i = 1'b1;
        s_wen_i = !is_wr;
        s_add_i = addr;
        s_wdata_i = $urandom;
        s_be_i = DW'($urandom) >> (DW - DW / 8);
        if (flush_with) flush_i = 1'b1;
        lat = 0;
        forever begin
            @(negedge clk);
            got = s_gnt_o;
            if (got) exp_q.push_back(is_wr ? {1'b1, {DW{1'b0}}} : {1'b0, addr & ~AW'(3)});
            @(posedge clk);
            #1;
            if (flush_with) flush_i = 1'b0;
            if (got) break;
            lat++;
            if (lat >= 500) begin
                fail_now("gnt_timeout", addr);
                break;
            end
        end
        s_req_i = 1'b0;
        s_wen_i = 1'b1;
        if (flush_with) m_valid = 1'b0;
        if (!fast) begin
            m_valid = 1'b1;
            m_line = addr / LINE_BYTES;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_s_gnt"}, s_gnt_o, 1'b0);
        check({tag, "_r_valid"}, s_r_valid_o, 1'b0);
        check({tag, "_r_rdata"}, s_r_rdata_o, '0);
        check({tag, "_r_opc"}, s_r_opc_o, 1'b0);
        check({tag, "_m_req"}, m_req_o, 1'b0);
        check({tag, "_m_add"}, m_add_o, '0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit fast;
        logic [AW-1:0] a;
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        check_reset_outputs("reset");

        // Cold read: full fill, response 7 cycles after request.
        access(1'b0, 32'h1A00_0008, 1'b0, lat, fast);
        check("cold_gnt_lat", lat, MISS_LAT);

        for (int i = 0; i < LW; i++) begin
            access(1'b0, 32'h1A00_0000 + 32'(4 * i), 1'b0, lat, fast);
            check("b2b_hit_lat", lat, 0);
        end

        access(1'b1, 32'h1A00_0004, 1'b0, lat, fast);
        check("write_gnt_lat", lat, 0);
        access(1'b0, 32'h1A00_0004, 1'b0, lat, fast);
        check("after_write_hit_lat", lat, 0);

        access(1'b0, 32'h1A00_0010, 1'b0, lat, fast);
        check("new_line_lat", lat, MISS_LAT);
        access(1'b0, 32'h1A00_0000, 1'b0, lat, fast);
        check("evicted_line_lat", lat, MISS_LAT);

        // Flush in the second fill cycle forces a second fill of the same line.
        expect_fill(32'h1A00_0020);
        fork
            access(1'b0, 32'h1A00_0020, 1'b0, lat, fast);
            begin
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                flush_i = 1'b1;
                @(posedge clk);
                #1;
                flush_i = 1'b0;
            end
        join
        check("flush_fill_lat", lat, 2 * MISS_LAT);

        // Flush with a simultaneous hit: the hit still serves, line then invalid.
        access(1'b0, 32'h1A00_0024, 1'b1, lat, fast);
        check("flush_same_cycle_hit_lat", lat, 0);
        access(1'b0, 32'h1A00_0028, 1'b0, lat, fast);
        check("after_flush_miss_lat", lat, MISS_LAT);

        // ROM withholds grant for 3 cycles on the second word.
        stall_arm = 1'b1;
        access(1'b0, 32'h1A00_0030, 1'b0, lat, fast);
        stall_arm = 1'b0;
        check("stall_gnt_lat", lat, MISS_LAT + 3);
        for (int i = 0; i < LW; i++) begin
            access(1'b0, 32'h1A00_0030 + 32'(4 * i), 1'b0, lat, fast);
            check("stall_line_hit_lat", lat, 0);
        end

        // Reset in the middle of a fill.
        rom_chk_en = 1'b0;
        s_req_i = 1'b1;
        s_wen_i = 1'b1;
        s_add_i = 32'h1A00_0040;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        s_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        check_reset_outputs("midfill_reset");
        rom_exp_q.delete();
        rom_chk_en = 1'b1;
        m_valid = 1'b0;
        access(1'b0, 32'h1A00_0044, 1'b0, lat, fast);
        check("post_reset_fill_lat", lat, MISS_LAT);

        // Randomized traffic over a few lines with ROM back-pressure and flushes.
        rand_stall = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                flush_i = 1'b1;
                @(posedge clk);
                #1;
                flush_i = 1'b0;
                m_valid = 1'b0;
            end
            a = 32'h1A00_0000 + 32'($urandom_range(0, 3) * LINE_BYTES) + 32'($urandom_range(0, 15));
            access($urandom_range(0, 4) == 0, a, $urandom_range(0, 9) == 0, lat, fast);
            if (fast) check("rand_fast_lat", lat, 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_stall = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("resp_q_drained", exp_q.size(), 0);
        check("rom_q_drained", rom_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
